// File: rtl/fpga_ip_example_pkg.sv
// Shared constants and types for the example GPIO write-traffic design.
`timescale 1ns/1ps
package fpga_ip_example_pkg;

    localparam int GPIO_WIDTH_DEF   = 8;
    localparam int FIRST_DELAY_DEF  = 48;
    localparam int WRITE_PERIOD_DEF = 30;

    typedef enum logic {
        TG_WAIT  = 1'b0,
        TG_WRITE = 1'b1
    } tg_state_t;

    // Counter only ever holds a value below the larger of the two delays.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/gpio_out.sv
// GPIO output register behind an always-ready valid/ready write slave.
`timescale 1ns/1ps
module gpio_out
    import fpga_ip_example_pkg::*;
#(
    parameter int GPIO_WIDTH = GPIO_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [GPIO_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic [GPIO_WIDTH-1:0] gpio_q
);

    assign wr_ready = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_q <= '0;
        end else if (wr_valid && wr_ready) begin
            gpio_q <= wr_data;
        end
    end

endmodule

// File: rtl/reset_sync.sv
// Reset conditioner: asserts immediately, releases two clk edges later.
`timescale 1ns/1ps
module reset_sync (
    input  logic clk,
    input  logic rst,
    output logic rst_int
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], 1'b0};
        end
    end

    assign rst_int = sync_reg[1];

endmodule

// File: rtl/traffic_gen.sv
// Write-traffic generator: waits, then offers one incrementing value per period.
`timescale 1ns/1ps
module traffic_gen
    import fpga_ip_example_pkg::*;
#(
    parameter int FIRST_DELAY  = FIRST_DELAY_DEF,
    parameter int WRITE_PERIOD = WRITE_PERIOD_DEF,
    parameter int GPIO_WIDTH   = GPIO_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  wr_valid,
    output logic [GPIO_WIDTH-1:0] wr_data,
    input  logic                  wr_ready
);

    localparam int CNT_W = cnt_width(FIRST_DELAY, WRITE_PERIOD);
    localparam logic [CNT_W-1:0] FIRST_LOAD  = CNT_W'(FIRST_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(WRITE_PERIOD - 1);

    tg_state_t             state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [GPIO_WIDTH-1:0] val_reg, val_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= TG_WAIT;
            cnt_reg   <= FIRST_LOAD;
            val_reg   <= GPIO_WIDTH'(1);
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            val_reg   <= val_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        val_next   = val_reg;
        wr_valid   = 1'b0;
        case (state_reg)
            TG_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = TG_WRITE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            TG_WRITE: begin
                // Value is held in val_reg, so it stays stable until accepted.
                wr_valid = 1'b1;
                if (wr_ready) begin
                    state_next = TG_WAIT;
                    cnt_next   = PERIOD_LOAD;
                    val_next   = val_reg + 1'b1;
                end
            end
            default: begin
                state_next = TG_WAIT;
            end
        endcase
    end

    assign wr_data = val_reg;

endmodule

// File: rtl/fpga_ip_example_top.sv
// Example design top: differential clock in, GPIO counter out.
`timescale 1ns/1ps
module fpga_ip_example_top
    import fpga_ip_example_pkg::*;
#(
    parameter int FIRST_DELAY  = FIRST_DELAY_DEF,
    parameter int WRITE_PERIOD = WRITE_PERIOD_DEF,
    parameter int GPIO_WIDTH   = GPIO_WIDTH_DEF
) (
    input  logic                  osc_300_p,
    input  logic                  osc_300_n,
    input  logic                  reset,
    output logic [GPIO_WIDTH-1:0] gpio_io_o
);

    logic                  clk;
    logic                  rst_int;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [GPIO_WIDTH-1:0] wr_data;

`ifdef FPGA_IP_EXAMPLE_USE_IBUFDS
    IBUFDS u_osc_buf (
        .I  (osc_300_p),
        .IB (osc_300_n),
        .O  (clk)
    );
`else
    // Behavioural stand-in for the vendor differential buffer.
    logic unused_osc_n;
    assign unused_osc_n = osc_300_n;
    assign clk          = osc_300_p;
`endif

    reset_sync u_reset_sync (
        .clk     (clk),
        .rst     (reset),
        .rst_int (rst_int)
    );

    traffic_gen #(
        .FIRST_DELAY  (FIRST_DELAY),
        .WRITE_PERIOD (WRITE_PERIOD),
        .GPIO_WIDTH   (GPIO_WIDTH)
    ) u_traffic_gen (
        .clk      (clk),
        .rst      (rst_int),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready)
    );

    gpio_out #(
        .GPIO_WIDTH (GPIO_WIDTH)
    ) u_gpio_out (
        .clk      (clk),
        .rst      (rst_int),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .gpio_q   (gpio_io_o)
    );

endmodule

// File: tb/tb_fpga_ip_example_top.sv
// Directed bench for the GPIO counter top plus a stalled-ready traffic_gen.
`timescale 1ns/1ps
module tb_fpga_ip_example_top;

    logic       osc_p;
    logic       osc_n;
    logic       reset;
    logic [7:0] gpio;

    logic       tg_rst;
    logic       tg_valid;
    logic [7:0] tg_data;
    logic       tg_ready;

    int cyc;
    int n_checks;
    int n_pass;

    initial osc_p = 1'b0;
    always #(10.0 / 6.0) osc_p = ~osc_p;
    assign osc_n = ~osc_p;

    always @(posedge osc_p) cyc <= cyc + 1;

    fpga_ip_example_top dut (
        .osc_300_p (osc_p),
        .osc_300_n (osc_n),
        .reset     (reset),
        .gpio_io_o (gpio)
    );

    // Short-delay generator with a bench-controlled ready for stall checks.
    traffic_gen #(
        .FIRST_DELAY  (4),
        .WRITE_PERIOD (3),
        .GPIO_WIDTH   (8)
    ) u_tg (
        .clk      (osc_p),
        .rst      (tg_rst),
        .wr_valid (tg_valid),
        .wr_data  (tg_data),
        .wr_ready (tg_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_change(input logic [7:0] prev, output int dcyc, output bit ok);
        int start;
        start = cyc;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge osc_p);
            if (gpio !== prev) begin
                ok = 1'b1;
                break;
            end
        end
        dcyc = cyc - start;
    endtask

    task automatic wait_tg_valid(output int dcyc, output bit ok);
        int start;
        start = cyc;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge osc_p);
            if (tg_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        dcyc = cyc - start;
    endtask

    initial begin
        int         dcyc;
        bit         ok;
        logic [7:0] exp_v;
        logic [7:0] prev;

        cyc      = 0;
        n_checks = 0;
        n_pass   = 0;
        tg_rst   = 1'b1;
        tg_ready = 1'b0;

        // Power-on reset and the fixed-time checkpoints.
        reset = 1'b1;
        #5;
        check("rst_hold_gpio", 32'(gpio), 32'h00);
        check("rst_hold_valid", 32'(dut.wr_valid), 32'h0);
        #5 reset = 1'b0;
        #0.5 check("release_gpio", 32'(gpio), 32'h00);
        #99.5 check("t100_gpio", 32'(gpio), 32'h00);
        #100 check("t200_gpio", 32'(gpio), 32'h01);
        #20 check("t220_gpio", 32'(gpio), 32'h01);
        $display("checkpoints after first reset: gpio_io_o=%02h", gpio);

        // 1 ns reset pulse must clear the output immediately.
        #2 reset = 1'b1;
        #0.5 check("pulse_gpio", 32'(gpio), 32'h00);
        #0.5 reset = 1'b0;
        #100 check("pulse_t100", 32'(gpio), 32'h00);
        #100 check("pulse_t200", 32'(gpio), 32'h01);
        #100 check("pulse_t300", 32'(gpio), 32'h02);
        $display("checkpoints after 1ns pulse: gpio_io_o=%02h", gpio);

        // Full wrap of the sequence with exact latency and cadence.
        @(negedge osc_p) reset = 1'b1;
        repeat (3) @(negedge osc_p);
        reset = 1'b0;
        prev = 8'h00;
        for (int k = 1; k <= 258; k++) begin
            exp_v = 8'(k);
            wait_change(prev, dcyc, ok);
            check("write_seen", 32'(ok), 32'h1);
            check("write_value", 32'(gpio), 32'(exp_v));
            check("write_cycles", 32'(dcyc), (k == 1) ? 32'd51 : 32'd31);
            $display("write %0d: gpio_io_o=%02h after %0d cycles", k, gpio, dcyc);
            prev = gpio;
            if (!ok) break;
        end

        // Reset while a write is being offered: nothing may land.
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge osc_p);
            if (dut.wr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("hs_valid_seen", 32'(ok), 32'h1);
        #0.5 reset = 1'b1;
        #0.5 check("hs_rst_gpio", 32'(gpio), 32'h00);
        check("hs_rst_valid", 32'(dut.wr_valid), 32'h0);
        @(negedge osc_p);
        check("hs_no_land", 32'(gpio), 32'h00);
        reset = 1'b0;
        wait_change(8'h00, dcyc, ok);
        check("hs_restart_seen", 32'(ok), 32'h1);
        check("hs_restart_value", 32'(gpio), 32'h01);
        check("hs_restart_cycles", 32'(dcyc), 32'd51);
        $display("restart after mid-handshake reset: gpio_io_o=%02h after %0d cycles", gpio, dcyc);

        // Stalled ready: value and valid must hold until accepted.
        @(negedge osc_p) tg_rst = 1'b0;
        wait_tg_valid(dcyc, ok);
        check("tg_first_seen", 32'(ok), 32'h1);
        check("tg_first_cycles", 32'(dcyc), 32'd4);
        for (int i = 0; i < 5; i++) begin
            check("tg_stall_valid", 32'(tg_valid), 32'h1);
            check("tg_stall_data", 32'(tg_data), 32'h01);
            @(negedge osc_p);
        end
        tg_ready = 1'b1;
        @(negedge osc_p);
        check("tg_after_accept", 32'(tg_valid), 32'h0);
        $display("tg stalled write accepted: data=01");
        wait_tg_valid(dcyc, ok);
        check("tg_second_seen", 32'(ok), 32'h1);
        check("tg_second_cycles", 32'(dcyc), 32'd3);
        check("tg_second_data", 32'(tg_data), 32'h02);
        $display("tg second write offered: data=%02h after %0d cycles", tg_data, dcyc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpga_ip_example_top.md
# fpga_ip_example_top

Self-contained FPGA demo top level: a small write-traffic generator drives an 8-bit GPIO output register over a simple valid/ready write channel. It takes a differential 300 MHz board oscillator and one board reset button. After each reset the GPIO output reads 0x00, then counts 0x01, 0x02, … at a fixed cadence. It is the top of the example design; nothing sits above it except board pins.

## Interface
Parameters:
- FIRST_DELAY, 48: clk cycles from internal reset release to the first GPIO write (160 ns at 300 MHz).
- WRITE_PERIOD, 30: clk cycles between successive GPIO writes (100 ns).
- GPIO_WIDTH, 8: GPIO output width.

Ports:
- osc_300_p  input  1  differential 300 MHz clock, positive leg.
- osc_300_n  input  1  differential clock, negative leg. There is one clock: clk = differential buffer of p/n. Behavioural model is clk = osc_300_p.
- reset  input  1  asynchronous, active-high reset.
- gpio_io_o  output  GPIO_WIDTH  GPIO output register.

## Operation
- Reset conditioning:
  - reset asserts the internal reset asynchronously, so pulses ≥1 ns must take effect.
  - Deassertion is synchronised with a 2-flop synchroniser on clk, giving rst_int.
- Traffic generator (TG) FSM states:
  - WAIT: load counter FIRST_DELAY-1 out of reset; count down to 0.
  - WRITE: assert wr_valid with wr_data = next value. Hold wr_valid and wr_data stable until wr_ready.
  - On handshake: increment next value mod 2^GPIO_WIDTH, reload counter WRITE_PERIOD-1, return to WAIT.
  - First value written is 0x01; the sequence wraps 0xFF -> 0x00 -> 0x01 and is free-running.
- GPIO slave: register gpio_q loads wr_data on wr_valid && wr_ready. wr_ready is constant 1. gpio_io_o = gpio_q.
- Reset at any time, including mid-handshake or mid-count:
  - gpio_io_o = 0x00, TG returns to WAIT with a full FIRST_DELAY count, and the sequence restarts at 0x01.
  - No partial write may land.

## Timing
- All outputs reset to 0: gpio_io_o = 0x00, wr_valid = 0.
- gpio_io_o clears asynchronously, within the reset pulse, with no clock needed.
- Write N (N≥1) lands at clock edge ≈ 2 (sync) + FIRST_DELAY + (N-1)·WRITE_PERIOD + 1 after the reset release edge.
- gpio_io_o updates on that edge, one cycle after wr_valid rises.
- With the defaults, measured from reset release: 0x00 until ~170 ns, 0x01 until ~270 ns, then 0x02.
  - Required checkpoints: at 100 ns = 0x00, 200/220 ns = 0x01, 300 ns = 0x02.
- Write cadence is exactly WRITE_PERIOD+1 cycles (the WRITE state cycle is included in the period). Implementers subtract it so the period is exactly WRITE_PERIOD if preferred; either way all checkpoints above must hold.

## Structure
- Package fpga_ip_example_pkg:
  - GPIO_WIDTH default.
  - Delay constants.
  - TG state enum {WAIT, WRITE}.
- Sub-modules:
  - reset_sync: 2-flop, async assert / sync deassert.
  - traffic_gen: FSM and counter.
  - gpio_out: register with valid/ready slave.
- Top instantiates the differential clock buffer (vendor primitive under synthesis, pass-through in simulation) plus the three sub-modules.

## Test plan
- Hold reset 10 ns, release -> gpio_io_o = 0x00 immediately and at +100 ns.
- After release, sample at +220 ns -> 0x01.
- 1 ns reset pulse at ~232 ns -> gpio_io_o = 0x00 during the pulse and at +100 ns; 0x01 at +200 ns; 0x02 at +300 ns.
- Run 256+ writes -> values 0x01…0xFF, 0x00, 0x01 in order, each held for exactly one period.
- Assert reset while wr_valid = 1 -> no update; after release the sequence restarts at 0x01 after the full first delay.
- Check wr_valid/wr_data stability: with wr_ready forced low in a bench variant, wr_data holds until accepted.
